// File: rtl/oam_dma_pkg.sv
// oam_dma_pkg: shared state type, register address and OAM size for the OAM DMA engine.
package oam_dma_pkg;
   typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_XFER} dma_state_t;
   localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
   localparam int OAM_LEN = 160;
   // Pages E0h..FFh fold onto C0h..DFh (echo RAM).
   function automatic logic [15:0] src_base(input logic [7:0] page);
      logic [7:0] p;
      p = page >= 8'hE0 ? page - 8'h20 : page;
      return {p, 8'h00};
   endfunction
endpackage

// File: rtl/oam_dma.sv
// oam_dma: copies 160 bytes from {page,00h} into OAM, owning the memory bus while active.
module oam_dma
   import oam_dma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_d_out,
   input  logic        cpu_write,
   output logic [7:0]  cpu_d_in,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_d_out,
   output logic        mem_write,
   input  logic [7:0]  mem_d_in,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_d,
   output logic        oam_we,
   output logic        dma_active
);
   dma_state_t state;
   logic [7:0] page, i, byte_q;
   logic reg_hit, reg_wr, last;
   assign reg_hit = cpu_addr == DMA_REG_ADDR;
   assign reg_wr = reg_hit && cpu_write;
   assign last = i == 8'(OAM_LEN - 1);
   assign mem_addr = dma_active ? src_base(page) + {8'h00, i} : cpu_addr;
   assign mem_d_out = dma_active ? 8'h00 : cpu_d_out;
   assign mem_write = !dma_active && cpu_write && !reg_hit;
   assign cpu_d_in = reg_hit ? page : dma_active ? 8'hFF : mem_d_in;
   assign oam_d = byte_q;
   // A restart only rewrites page/i/state; a read in flight still lands in OAM next cycle.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= DMA_IDLE;
         page <= '0;
         i <= '0;
         byte_q <= '0;
         oam_addr <= '0;
         oam_we <= 1'b0;
         dma_active <= 1'b0;
      end else begin
         oam_we <= state == DMA_XFER;
         if (state == DMA_XFER) begin
            byte_q <= mem_d_in;
            oam_addr <= i;
         end
         dma_active <= reg_wr || state != DMA_IDLE;
         if (reg_wr) begin
            page <= cpu_d_out;
            i <= '0;
            state <= DMA_START;
         end else if (state == DMA_START)
            state <= DMA_XFER;
         else if (state == DMA_XFER) begin
            i <= last ? '0 : i + 8'd1;
            state <= last ? DMA_IDLE : DMA_XFER;
         end
      end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: random CPU traffic and DMA triggers checked against a cycle-scheduled transfer model.
module tb_oam_dma;
   localparam int DEPTH = 4096;
   logic clk = 1'b0, rst = 1'b1;
   logic [15:0] cpu_addr = '0, mem_addr;
   logic [7:0] cpu_d_out = '0, cpu_d_in, mem_d_out, mem_d_in, oam_addr, oam_d;
   logic cpu_write = 1'b0, mem_write, oam_we, dma_active;
   int n_cmp = 0, n_bad = 0, cyc = 0, t0;
   bit exp_act[DEPTH];
   bit exp_we[DEPTH];
   logic [7:0] exp_oa[DEPTH], exp_od[DEPTH], page_m = '0;
   int exp_ma[DEPTH];

   function automatic logic [7:0] memfn(input logic [15:0] a);
      return 8'(a[7:0] * 8'd3) ^ a[15:8] ^ 8'h5C;
   endfunction
   assign mem_d_in = memfn(mem_addr);

   oam_dma dut (.clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out),
                .cpu_write(cpu_write), .cpu_d_in(cpu_d_in), .mem_addr(mem_addr),
                .mem_d_out(mem_d_out), .mem_write(mem_write), .mem_d_in(mem_d_in),
                .oam_addr(oam_addr), .oam_d(oam_d), .oam_we(oam_we), .dma_active(dma_active));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   // A write at cycle r: reads at r+2..r+161, OAM writes at r+3..r+162, busy r+1..r+162.
   // Anything of an older transfer later than its pending write at r+1 is dropped.
   function automatic void trigger(input int r, input logic [7:0] p);
      int pi = int'(p);
      int base = pi >= 224 ? (pi - 32) * 256 : pi * 256;
      page_m = p;
      for (int c = r + 1; c < DEPTH; c++) begin
         exp_act[c] = 1'b0;
         exp_ma[c] = -1;
         if (c >= r + 2) exp_we[c] = 1'b0;
      end
      for (int k = 1; k <= 162; k++) exp_act[r + k] = 1'b1;
      for (int k = 0; k < 160; k++) begin
         exp_ma[r + 2 + k] = base + k;
         exp_we[r + 3 + k] = 1'b1;
         exp_oa[r + 3 + k] = 8'(k);
         exp_od[r + 3 + k] = memfn(16'(base + k));
      end
   endfunction

   function automatic void model_reset(input int r);
      page_m = '0;
      for (int c = r; c < DEPTH; c++) begin
         exp_act[c] = 1'b0;
         exp_we[c] = 1'b0;
         exp_ma[c] = -1;
      end
   endfunction

   task automatic check_cycle();
      bit act = exp_act[cyc];
      chk("dma_active", {15'd0, dma_active}, {15'd0, act});
      chk("oam_we", {15'd0, oam_we}, {15'd0, exp_we[cyc]});
      if (exp_we[cyc]) begin
         chk("oam_addr", {8'd0, oam_addr}, {8'd0, exp_oa[cyc]});
         chk("oam_d", {8'd0, oam_d}, {8'd0, exp_od[cyc]});
      end
      if (act) begin
         if (exp_ma[cyc] >= 0) chk("dma_mem_addr", mem_addr, 16'(exp_ma[cyc]));
         chk("dma_mem_d_out", {8'd0, mem_d_out}, 16'h0000);
      end else begin
         chk("idle_mem_addr", mem_addr, cpu_addr);
         chk("idle_mem_d_out", {8'd0, mem_d_out}, {8'd0, cpu_d_out});
      end
      chk("mem_write", {15'd0, mem_write}, {15'd0, !act && cpu_write && cpu_addr != 16'hFF46});
      chk("cpu_d_in", {8'd0, cpu_d_in},
          {8'd0, cpu_addr == 16'hFF46 ? page_m : act ? 8'hFF : memfn(cpu_addr)});
   endtask

   task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
      cpu_addr = a;
      cpu_d_out = d;
      cpu_write = w;
      @(negedge clk);
      check_cycle();
      if (w && a == 16'hFF46) trigger(cyc, d);
      @(posedge clk);
      #1 cyc++;
   endtask

   task automatic rand_step();
      logic [15:0] a;
      logic w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
         0: a = 16'h8000;
         1: a = 16'hC000;
         2: a = 16'($urandom);
         default: a = 16'hFF46;
      endcase
      if (a == 16'hFF46) w = 1'b0;
      step(a, 8'($urandom), w);
   endtask

   task automatic run_to(input int c);
      while (cyc < c) rand_step();
   endtask

   task automatic reset_mid();
      cpu_addr = 16'hFF46;
      cpu_write = 1'b0;
      chk("pre_rst_oam_we", {15'd0, oam_we}, 16'h0001);
      #1 rst = 1'b1;
      #1;
      chk("rst_oam_we", {15'd0, oam_we}, 16'h0000);
      chk("rst_active", {15'd0, dma_active}, 16'h0000);
      chk("rst_page", {8'd0, cpu_d_in}, 16'h0000);
      #1 rst = 1'b0;
      model_reset(cyc);
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1 cyc++;
   endtask

   initial begin
      for (int c = 0; c < DEPTH; c++) exp_ma[c] = -1;
      cpu_addr = 16'hFF46;
      #3;
      chk("reset_active", {15'd0, dma_active}, 16'h0000);
      chk("reset_oam_we", {15'd0, oam_we}, 16'h0000);
      chk("reset_page", {8'd0, cpu_d_in}, 16'h0000);
      #9 rst = 1'b0;
      @(posedge clk);
      #1 cyc = 0;
      step(16'hC000, 8'h5A, 1'b1);
      step(16'hFF46, 8'hC1, 1'b1);
      run_to(cyc + 170);
      step(16'hFF46, 8'hF0, 1'b1);
      run_to(cyc + 170);
      t0 = cyc;
      step(16'hFF46, 8'h40, 1'b1);
      run_to(t0 + 52);
      step(16'hFF46, 8'h80, 1'b1);
      run_to(cyc + 170);
      t0 = cyc;
      step(16'hFF46, 8'hE5, 1'b1);
      run_to(t0 + 102);
      reset_mid();
      run_to(cyc + 20);
      for (int n = 0; n < 6; n++) begin
         step(16'hFF46, 8'($urandom), 1'b1);
         run_to(cyc + int'($urandom_range(20, 200)));
      end
      run_to(cyc + 170);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
